// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and a single-cycle flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && o_valid && !i_flush;

  // NOTE: storage carries no reset; r_count gates o_valid, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Sequential instruction prefetcher: fetch FSM and pc logic in front of a {pc, instr} FIFO.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_read,
  input  logic                     mem_waitrequest,
  input  logic [DATA_W-1:0]        mem_readdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_W-1:0]        instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0]   count
);

  fetch_state_e              r_state;
  fetch_state_e              w_state_nxt;
  logic [ADDR_W-1:0]         r_fetch_pc;
  logic [ADDR_W-1:0]         w_pc_nxt;
  logic [ADDR_W-1:0]         r_target;
  logic [ADDR_W-1:0]         w_target_nxt;
  logic                      w_full;
  logic                      w_accept;
  logic                      w_stall;
  logic                      w_push;
  logic                      w_pop;
  logic [ADDR_W+DATA_W-1:0]  w_head;

  // DISCARD keeps the abandoned request alive until memory accepts it.
  assign mem_read    = ((r_state == ST_FETCH) && !w_full) || (r_state == ST_DISCARD);
  assign mem_address = r_fetch_pc;
  assign w_accept    = mem_read && !mem_waitrequest;
  assign w_stall     = mem_read && mem_waitrequest;
  assign w_push      = w_accept && (r_state == ST_FETCH) && !redirect;
  assign w_pop       = instr_valid && instr_ready && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_target   <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      r_target   <= w_target_nxt;
    end
  end

  // NOTE: hold values are assigned first so no path through this block leaves a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_fetch_pc;
    w_target_nxt = r_target;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
        if (redirect) w_pc_nxt = redirect_pc;
      end
      ST_FETCH: begin
        if (redirect) begin
          if (w_stall) begin
            w_state_nxt  = ST_DISCARD;
            w_target_nxt = redirect_pc;
          end else begin
            w_pc_nxt = redirect_pc;
          end
        end else if (w_accept) begin
          w_pc_nxt = r_fetch_pc + ADDR_W'(4);
        end
      end
      ST_DISCARD: begin
        // A redirect arriving with the accept wins over the older latched target.
        if (w_accept) begin
          w_state_nxt = ST_FETCH;
          w_pc_nxt    = redirect ? redirect_pc : r_target;
        end else if (redirect) begin
          w_target_nxt = redirect_pc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect),
    .i_push      (w_push),
    .i_push_data ({mem_address, mem_readdata}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (instr_valid),
    .o_full      (w_full),
    .o_count     (count)
  );

  assign instr_data = w_head[DATA_W-1:0];
  assign instr_pc   = w_head[ADDR_W+DATA_W-1 -: ADDR_W];

endmodule
